// File: rtl/sound_ctrl.sv
// sound_ctrl: 1-bit square-wave tone generator. While the synchronised
// enable is high it plays an 8-note C-major scale (C4..C5) in a loop.
// Each note lasts NOTE_LEN clocks. The output toggles every half[idx] clocks.
module sound_ctrl #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned NOTE_LEN = 50_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic clk,
    input  logic rst,     // asynchronous, active low
    input  logic sw,      // asynchronous play enable
    output logic signal
);

    // Half-period in clocks for a tone of frequency f, floored, never below 1
    function automatic logic [CNT_W-1:0] half_of(input longint f);
        longint h;
        h = longint'(CLK_HZ) / (2 * f);
        if (h < 1) h = 1;
        return CNT_W'(h);
    endfunction

    localparam logic [CNT_W-1:0] HALF [8] = '{
        half_of(262), half_of(294), half_of(330), half_of(349),
        half_of(392), half_of(440), half_of(494), half_of(523)
    };

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_LEN - 1);

    logic             sw_m_q, sw_s_q;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       idx_q,   idx_d;
    logic             signal_q, signal_d;
    logic [CNT_W-1:0] half_cur;

    // Two-flop synchroniser for the board switch; no debounce
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_m_q <= 1'b0;
            sw_s_q <= 1'b0;
        end else begin
            sw_m_q <= sw;
            sw_s_q <= sw_m_q;
        end
    end

    // Next-state for phase, note timer, note index and output level
    always_comb begin
        half_cur = HALF[idx_q];
        phase_d  = phase_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        signal_d = signal_q;
        if (!sw_s_q) begin
            // Silent: everything parked so re-enable starts at note 0, low
            phase_d  = '0;
            timer_d  = '0;
            idx_d    = '0;
            signal_d = 1'b0;
        end else if (timer_q == NOTE_LAST) begin
            // Note boundary: restart the phase, hold the output level
            timer_d = '0;
            idx_d   = idx_q + 3'd1;
            phase_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
            if (phase_q == half_cur - 1'b1) begin
                phase_d  = '0;
                signal_d = ~signal_q;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // State registers; signal is a direct flop output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= '0;
            timer_q  <= '0;
            idx_q    <= '0;
            signal_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            signal_q <= signal_d;
        end
    end

    assign signal = signal_q;

endmodule

// File: tb/tb_sound_ctrl.sv
// tb_sound_ctrl: randomized and directed stimulus against an arithmetic
// reference model of the scale player (level derived from enabled-cycle count).
module tb_sound_ctrl;

    localparam int unsigned CLK_HZ   = 1_000_000;
    localparam int unsigned NOTE_LEN = 8000;
    localparam int unsigned FREQ [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sw  = 1'b1;
    logic signal;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic        s1 = 1'b0, s2 = 1'b0;
    int unsigned n  = 0;      // enabled edges since playback (re)started
    logic        exp_sig = 1'b0;

    sound_ctrl #(.CLK_HZ(CLK_HZ), .NOTE_LEN(NOTE_LEN), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .sw(sw), .signal(signal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned half(input int unsigned i);
        int unsigned h;
        h = CLK_HZ / (2 * FREQ[i % 8]);
        return (h == 0) ? 1 : h;
    endfunction

    // Level after n enabled edges: each note toggles floor(m/half) times for
    // m edges into it; the boundary edge itself never toggles.
    function automatic logic level(input int unsigned cnt);
        int unsigned k, m;
        logic l;
        k = cnt / NOTE_LEN;
        m = cnt % NOTE_LEN;
        l = 1'b0;
        for (int j = 0; j < int'(k); j++)
            l ^= 1'(((NOTE_LEN - 1) / half(j)) & 1);
        l ^= 1'((m / half(k)) & 1);
        return l;
    endfunction

    // One clock: advance the model at the edge, check on the falling edge
    task automatic step(input string tag);
        logic en;
        @(posedge clk);
        if (!rst) begin
            s1 = 1'b0; s2 = 1'b0; n = 0;
        end else begin
            en = s2; s2 = s1; s1 = sw;
            n  = en ? n + 1 : 0;
        end
        exp_sig = level(n);
        @(negedge clk);
        chk(tag, {31'd0, signal}, {31'd0, exp_sig});
    endtask

    initial begin
        int guard;
        // held in reset with the switch on and clock running
        sw = 1'b1;
        rst = 1'b0;
        #1 chk("rst_init", {31'd0, signal}, 32'd0);
        repeat (20) step("rst_hold");

        // play from note 0 through all notes and the 7->0 wrap
        rst = 1'b1;
        repeat (65000) step("play");

        // disable mid-note for 5000 cycles
        sw = 1'b0;
        repeat (5000) step("disable");

        // re-enable: restart at note 0
        sw = 1'b1;
        repeat (4000) step("reenable");

        // random single-cycle glitches on the switch
        for (int i = 0; i < 10000; i++) begin
            sw = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step("glitch");
        end
        sw = 1'b1;

        // asynchronous reset while the output is high
        guard = 0;
        while (exp_sig !== 1'b1 && guard < 5000) begin
            step("seek_high");
            guard++;
        end
        chk("seek_high_timeout", {31'd0, exp_sig}, 32'd1);
        #2 rst = 1'b0;
        #1 chk("async_rst", {31'd0, signal}, 32'd0);
        s1 = 1'b0; s2 = 1'b0; n = 0; exp_sig = 1'b0;
        repeat (10) step("rst_mid");
        rst = 1'b1;
        repeat (4000) step("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sound_ctrl.md
Name: sound_ctrl

Overview:
- Tone generator for a 1-bit audio output (buzzer/speaker pin).
- While the enable switch is on, it steps through a fixed 8-note C-major scale (C4..C5), repeating.
- Each note is a 50% duty square wave held for a programmable number of clock cycles.
- Sits directly between a board switch and the audio output pin; all timing is derived from the single system clock.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz; used to derive note half-periods at elaboration.
- NOTE_LEN, 50_000_000, duration of each note in clock cycles (must be ≥ 1).
- CNT_W, 32, width of internal phase and note counters (must hold max(half-period, NOTE_LEN)).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low: asserted (0) clears all state immediately; deassertion is sampled on clk.
- sw  input  1  play enable from a board switch; asynchronous to clk; 1 = play, 0 = silent.
- signal  output  1  registered square-wave audio output.

Behaviour:
- Reset (rst=0): sync flops, phase counter, note timer and note index go to 0; signal=0. Reset takes effect without waiting for a clock edge.
- Input sync: sw passes through 2 flops to give sw_s, so a change on sw reaches sw_s 2 clk edges later. No debounce.
- Note table (index 0..7): 262, 294, 330, 349, 392, 440, 494, 523 Hz.
  - half[i] = CLK_HZ / (2*f_i), integer floor, computed as constants.
  - Any half[i] of 0 is clamped to 1.
- Disabled (sw_s=0): on each clk, phase counter, note timer and note index are forced to 0 and signal is forced to 0. The output is silent within 1 cycle of sw_s falling.
- Enabled (sw_s=1), each clk:
  - Phase counter: if phase == half[idx]-1, then phase←0 and signal←~signal; else phase←phase+1.
  - Note timer: if timer == NOTE_LEN-1, then timer←0, idx←(idx+1) mod 8, and phase←0. This phase reset overrides the phase rule above. signal holds its level, with no toggle that cycle. Otherwise timer←timer+1.
- First toggle after enable: signal rises to 1 at the half[0]-th enabled clock edge.
- Square-wave period is 2*half[idx] cycles. Each level lasts exactly half[idx] cycles, except across a note boundary.
- Index wraps 7→0 indefinitely.
- Re-enabling after a disable always restarts at note 0 with signal=0.
- Reset mid-note: immediate return to the reset state. Playback restarts from note 0 once rst=1 and sw_s=1.
- No other outputs or handshakes. signal is a direct flop output with no combinational path from any input.

Test Plan:
All scenarios use CLK_HZ=1_000_000 and NOTE_LEN=8000, giving half[0]=1908, half[1]=1700, half[5]=1136.
- Reset: hold rst=0 with sw=1 and clk toggling → signal=0 throughout. Assert rst=0 asynchronously mid-tone → signal=0 before the next clk edge.
- Note 0 tone: release rst=1 with sw=1 → first rising edge of signal 2+1908 cycles after sw_s settles. Subsequent edges every 1908 cycles (period 3816).
- Note advance: after 8000 enabled cycles, half-period changes to 1700. After 40000 cycles (note 5), half-period is 1136. After 64000 cycles, half-period is back to 1908 (wrap 7→0).
- Disable: drive sw=0 mid-note → signal=0 by 3 cycles later and stays 0 while sw=0, with no toggles.
- Re-enable: after a 5000-cycle-off period, drive sw=1 → playback restarts at note 0. First edge at 2+1908 cycles, matching the initial start.
- Glitch: pulse sw=0 for 1 cycle → either no effect or a clean restart at note 0. signal must never toggle at any spacing other than a valid half-period.
